// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port, negedge-operated DataMemory.
// Each access takes three cycles: IDLE (grant) -> ACCESS (memory op) -> DONE (ack pulse).
module dmem_arbiter #(
    parameter int DEPTH = 311,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          We0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] WData0,
    output logic          Ack0,
    input  logic          Req1,
    input  logic          We1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData1,
    output logic          Ack1,
    output logic [DW-1:0] RData,
    output logic          Err,
    output logic          MemRW,
    output logic [AW-1:0] MemDAddr,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e        state_q;
    logic          last_grant_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic          grant_d;
    logic          in_range;

    // Under contention the port that did not win last time goes next.
    always_comb begin
        grant_d = 1'b0;
        if (Req0 && Req1) begin
            grant_d = ~last_grant_q;
        end else if (Req1) begin
            grant_d = 1'b1;
        end
    end

    // Full-width compare: high address bits are never dropped.
    assign in_range = (addr_q < AW'(DEPTH));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            // NOTE: Ack/Err default low every cycle, so they can only pulse for the single DONE cycle.
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Req0 || Req1) begin
                        last_grant_q <= grant_d;
                        we_q         <= grant_d ? We1 : We0;
                        addr_q       <= grant_d ? Addr1 : Addr0;
                        wdata_q      <= grant_d ? WData1 : WData0;
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rdata_q <= (!we_q && in_range) ? MemDataOut : '0;
                    ack0_q  <= ~last_grant_q;
                    ack1_q  <= last_grant_q;
                    err_q   <= ~in_range;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write strobe is gated by state, so a reset that leaves ACCESS also kills the strobe.
    assign MemRW     = (state_q == S_ACCESS) && we_q && in_range;
    assign MemDAddr  = addr_q;
    assign MemDataIn = wdata_q;
    assign Ack0      = ack0_q;
    assign Ack1      = ack1_q;
    assign Err       = err_q;
    assign RData     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized two-port traffic
// against a word-array memory model and a round-robin reference.
module tb_dmem_arbiter;

    localparam int DEPTH = 311;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          CLK;
    logic          Reset;
    logic          Req0, We0, Ack0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] WData0;
    logic          Req1, We1, Ack1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData1;
    logic [DW-1:0] RData;
    logic          Err;
    logic          MemRW;
    logic [AW-1:0] MemDAddr;
    logic [DW-1:0] MemDataIn;
    logic [DW-1:0] MemDataOut;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Req0       (Req0),
        .We0        (We0),
        .Addr0      (Addr0),
        .WData0     (WData0),
        .Ack0       (Ack0),
        .Req1       (Req1),
        .We1        (We1),
        .Addr1      (Addr1),
        .WData1     (WData1),
        .Ack1       (Ack1),
        .RData      (RData),
        .Err        (Err),
        .MemRW      (MemRW),
        .MemDAddr   (MemDAddr),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port DataMemory: operation on the falling edge.
    logic [DW-1:0] mem [DEPTH];
    always @(negedge CLK) begin
        if (MemRW) begin
            if (MemDAddr < DEPTH) mem[MemDAddr] <= MemDataIn;
        end else begin
            MemDataOut <= (MemDAddr < DEPTH) ? mem[MemDAddr] : '0;
        end
    end

    // Reference state: memory image, last winner, and each port's pending request.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_last;
    bit            p_req [2];
    bit            p_we  [2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_data[2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        Req0 = p_req[0]; We0 = p_we[0]; Addr0 = p_addr[0]; WData0 = p_data[0];
        Req1 = p_req[1]; We1 = p_we[1]; Addr1 = p_addr[1]; WData1 = p_data[1];
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            p_req[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_data[i] = '0;
        end
        drive();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        ref_last = 1'b1;
        check("rst_ack0", 32'(Ack0), 0);
        check("rst_ack1", 32'(Ack1), 0);
        check("rst_err", 32'(Err), 0);
        check("rst_rdata", RData, 0);
        check("rst_memrw", 32'(MemRW), 0);
        check("rst_daddr", MemDAddr, 0);
        check("rst_din", MemDataIn, 0);
    endtask

    // One arbitrated access from the current pending set. The winner's request is
    // retired unless keep=1, in which case it stays high and is served again later.
    task automatic run(input bit keep);
        bit            win;
        bit            exp_in;
        bit            exp_rw;
        logic [DW-1:0] exp_rd;
        drive();
        win    = (p_req[0] && p_req[1]) ? !ref_last : p_req[1];
        exp_in = p_addr[win] < DEPTH;
        exp_rw = p_we[win] && exp_in;
        exp_rd = (!p_we[win] && exp_in) ? ref_mem[int'(p_addr[win])] : '0;
        step();
        check("acc_memrw", 32'(MemRW), 32'(exp_rw));
        check("acc_daddr", MemDAddr, p_addr[win]);
        check("acc_din", MemDataIn, p_data[win]);
        check("acc_noack", {Ack1, Ack0}, 0);
        step();
        check("done_ack0", 32'(Ack0), 32'(win == 1'b0));
        check("done_ack1", 32'(Ack1), 32'(win == 1'b1));
        check("done_err", 32'(Err), 32'(!exp_in));
        check("done_rdata", RData, exp_rd);
        check("done_memrw", 32'(MemRW), 0);
        if (exp_rw) ref_mem[int'(p_addr[win])] = p_data[win];
        ref_last = win;
        if (!keep) p_req[win] = 0;
        drive();
        step();
        check("idle_ack", {Ack1, Ack0}, 0);
        check("idle_err", 32'(Err), 0);
        check("idle_rdata_hold", RData, exp_rd);
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
        p_req[p] = 1; p_we[p] = we; p_addr[p] = addr; p_data[p] = data;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        MemDataOut = '0;
        Reset      = 1'b1;
        step();
        do_reset();

        // Port 0 write then read back.
        set_port(0, 1, 5, 32'hDEADBEEF);
        run(0);
        set_port(0, 0, 5, 32'h0);
        run(0);

        // Continuous contention after reset: 0,1,0,1.
        do_reset();
        set_port(0, 0, 5, 32'h0);
        set_port(1, 0, 6, 32'h0);
        for (int k = 0; k < 4; k++) begin
            run(1);
            check("rr_order", 32'(ref_last), 32'(k % 2));
        end
        p_req[0] = 0;
        p_req[1] = 0;
        drive();
        step();

        // Last valid word, then first invalid word and a high-bit address.
        set_port(1, 1, 310, 32'h12345678);
        run(0);
        set_port(1, 0, 310, 32'h0);
        run(0);
        set_port(1, 1, 311, 32'hFFFFFFFF);
        run(0);
        set_port(1, 1, 32'h8000_0005, 32'hFFFFFFFF);
        run(0);
        set_port(1, 0, 310, 32'h0);
        run(0);
        set_port(0, 0, 5, 32'h0);
        run(0);

        // Inputs changed after the grant are ignored.
        set_port(0, 1, 7, 32'hA5A50007);
        drive();
        step();
        check("chg_daddr", MemDAddr, 7);
        check("chg_memrw", 32'(MemRW), 1);
        Addr0  = 9;
        WData0 = 32'h09090909;
        step();
        check("chg_ack0", 32'(Ack0), 1);
        check("chg_daddr_hold", MemDAddr, 7);
        ref_mem[7] = 32'hA5A50007;
        ref_last   = 0;
        p_req[0]   = 0;
        drive();
        step();
        set_port(0, 0, 7, 32'h0);
        run(0);
        set_port(0, 0, 9, 32'h0);
        run(0);

        // Reset during ACCESS of a write: the negedge write commits, no ack follows.
        set_port(0, 1, 20, 32'hCAFE0020);
        drive();
        step();
        check("mid_memrw", 32'(MemRW), 1);
        p_req[0] = 0;
        drive();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        ref_mem[20] = 32'hCAFE0020;
        ref_last    = 1;
        check("mid_noack", {Ack1, Ack0}, 0);
        check("mid_memrw_off", 32'(MemRW), 0);
        check("mid_daddr", MemDAddr, 0);
        step();
        check("mid_noack_late", {Ack1, Ack0}, 0);
        set_port(0, 0, 20, 32'h0);
        run(0);

        // Randomized traffic, with pending losers kept high until served.
        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && ($urandom_range(0, 2) != 0)) begin
                    logic [AW-1:0] a;
                    a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 330));
                    set_port(p, 1'($urandom_range(0, 1)), a, DW'($urandom));
                end
            end
            if (!p_req[0] && !p_req[1]) set_port(0, 0, AW'($urandom_range(0, 310)), '0);
            run(0);
        end
        p_req[0] = 0;
        p_req[1] = 0;
        drive();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
